// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants.
// The transmitter can import the same package to stay in lock-step.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        RECEIVE = 2'd2,
        STOP    = 2'd3
    } rx_state_t;

    localparam int         OVERSAMPLE  = 16;
    localparam logic [3:0] MID_SAMPLE  = 4'd7;
    localparam logic [3:0] LAST_SAMPLE = 4'd15;

endpackage

// File: rtl/rx_synchronizer.sv
// Two-flop synchroniser for the asynchronous rx line plus a falling-edge detect.
// Every flop resets to 1 so a line idling high never looks like a start edge.
module rx_synchronizer (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s,
    output logic rx_fall
);

    logic rx_meta;
    logic prev_rx_s;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            prev_rx_s <= 1'b1;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            prev_rx_s <= rx_s;
        end
    end

    assign rx_fall = prev_rx_s & ~rx_s;

endmodule

// File: rtl/receiver.sv
// UART receive stage: 16x oversampled, LSB-first, one start and one stop bit.
// Delivers words over valid/ready and pulses frame-error and overrun flags.
module receiver
    import uart_pkg::*;
#(
    parameter int DATA_LENGTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   baud_timer,
    input  logic                   rx,
    input  logic                   rx_ready,
    output logic [DATA_LENGTH-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   rx_frame_error,
    output logic                   rx_overrun
);

    localparam int IDX_W  = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;
    localparam int BAUD_W = $clog2(OVERSAMPLE);
    localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(DATA_LENGTH - 1);

    logic rx_s;
    logic rx_fall;

    rx_state_t              state, next_state;
    logic [BAUD_W-1:0]      baud_count, next_baud_count;
    logic [IDX_W-1:0]       bit_index, next_bit_index;
    logic [DATA_LENGTH-1:0] shift, next_shift;
    logic                   stop_good;
    logic                   stop_bad;

    rx_synchronizer u_sync (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .rx_s    (rx_s),
        .rx_fall (rx_fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            baud_count <= '0;
            bit_index  <= '0;
            shift      <= '0;
        end else begin
            state      <= next_state;
            baud_count <= next_baud_count;
            bit_index  <= next_bit_index;
            shift      <= next_shift;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        next_state      = state;
        next_baud_count = baud_count;
        next_bit_index  = bit_index;
        next_shift      = shift;
        stop_good       = 1'b0;
        stop_bad        = 1'b0;

        case (state)
            IDLE: begin
                if (rx_fall) begin
                    next_baud_count = '0;
                    next_state      = START;
                end
            end

            START: begin
                if (baud_timer) begin
                    if (baud_count == MID_SAMPLE) begin
                        // A start bit that is high again at mid-bit was only a glitch.
                        if (!rx_s) begin
                            next_baud_count = '0;
                            next_bit_index  = '0;
                            next_state      = RECEIVE;
                        end else begin
                            next_state = IDLE;
                        end
                    end else begin
                        next_baud_count = baud_count + 1'b1;
                    end
                end
            end

            RECEIVE: begin
                if (baud_timer) begin
                    if (baud_count == LAST_SAMPLE) begin
                        next_shift      = {rx_s, shift[DATA_LENGTH-1:1]};
                        next_baud_count = '0;
                        if (bit_index == LAST_INDEX) begin
                            next_state = STOP;
                        end else begin
                            next_bit_index = bit_index + 1'b1;
                        end
                    end else begin
                        next_baud_count = baud_count + 1'b1;
                    end
                end
            end

            STOP: begin
                if (baud_timer) begin
                    if (baud_count == LAST_SAMPLE) begin
                        stop_good  = rx_s;
                        stop_bad   = ~rx_s;
                        next_state = IDLE;
                    end else begin
                        next_baud_count = baud_count + 1'b1;
                    end
                end
            end

            default: next_state = IDLE;
        endcase
    end

    // A completed word replaces the held one only if the slot is free or being accepted now.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            rx_frame_error <= 1'b0;
            rx_overrun     <= 1'b0;
        end else begin
            rx_frame_error <= stop_bad;
            rx_overrun     <= 1'b0;
            if (stop_good) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_receiver.sv
// Scoreboard bench for the UART receiver: a serial-line driver queues the expected
// events, and an independent monitor checks each word, frame error and overrun.
module tb_receiver;
    import uart_pkg::*;

    localparam int DL = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          baud_timer;
    logic          rx;
    logic          rx_ready;
    logic [DL-1:0] rx_data;
    logic          rx_valid;
    logic          rx_frame_error;
    logic          rx_overrun;

    typedef enum int {EV_WORD, EV_FERR, EV_OVR} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  checks      = 0;
    int  errors      = 0;
    int  tick_period = 1;
    int  tick_cnt    = 0;

    always #5 clk = ~clk;

    receiver #(.DATA_LENGTH(DL)) dut (
        .clk            (clk),
        .reset          (reset),
        .baud_timer     (baud_timer),
        .rx             (rx),
        .rx_ready       (rx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_frame_error (rx_frame_error),
        .rx_overrun     (rx_overrun)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Baud tick: one cycle high every tick_period clocks (tick_period=1 ties it high).
    initial begin
        baud_timer = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_cnt >= tick_period - 1) begin
                baud_timer = 1'b1;
                tick_cnt   = 0;
            end else begin
                baud_timer = 1'b0;
                tick_cnt++;
            end
        end
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (baud_timer !== 1'b1);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        rx = b;
        wait_ticks(OVERSAMPLE);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop_bit);
        @(negedge clk);
        rx = 1'b1;
        wait_ticks(4);
    endtask

    task automatic expect_ev(input ev_kind_t kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input ev_kind_t kind, input string name);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: unexpected event with rx_data=0x%0h, none expected", name, rx_data);
        end else begin
            e = exp_q.pop_front();
            check({name, " kind"}, kind, e.kind);
            if (kind != EV_FERR) check({name, " data"}, rx_data, e.data);
        end
    endtask

    // Monitor: a word is newly loaded when valid rises, or stays high right after an accept.
    initial begin
        logic prev_valid;
        logic prev_ready;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_valid = 1'b0;
                prev_ready = 1'b0;
            end else begin
                if (rx_frame_error) pop_check(EV_FERR, "frame_error");
                if (rx_overrun) pop_check(EV_OVR, "overrun");
                if (rx_valid && (!prev_valid || prev_ready)) pop_check(EV_WORD, "word");
                prev_valid = rx_valid;
                prev_ready = rx_ready;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       stop_ok;
        logic [7:0] partial;

        reset    = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset rx_data", rx_data, 0);
        check("reset rx_valid", rx_valid, 0);
        check("reset frame_error", rx_frame_error, 0);
        check("reset overrun", rx_overrun, 0);
        check("reset state", dut.state, IDLE);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_ticks(20);

        // Plain frame, consumer always ready.
        expect_ev(EV_WORD, 8'hA5);
        send_frame(8'hA5, 1'b1);

        // Short low glitch must not start a frame.
        @(negedge clk);
        rx = 1'b0;
        wait_ticks(4);
        @(negedge clk);
        rx = 1'b1;
        wait_ticks(32);
        @(negedge clk);
        check("glitch back to idle", dut.state, IDLE);
        expect_ev(EV_WORD, 8'h3C);
        send_frame(8'h3C, 1'b1);

        // Bad stop bit, then recovery.
        expect_ev(EV_FERR, 8'h00);
        send_frame(8'hFF, 1'b0);
        expect_ev(EV_WORD, 8'h12);
        send_frame(8'h12, 1'b1);

        // Overrun: second word arrives while the first is still held.
        @(posedge clk);
        #1 rx_ready = 1'b0;
        expect_ev(EV_WORD, 8'h11);
        send_frame(8'h11, 1'b1);
        expect_ev(EV_OVR, 8'h11);
        send_frame(8'h22, 1'b1);
        @(negedge clk);
        check("overrun keeps valid", rx_valid, 1);
        @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
        @(negedge clk);
        check("valid drops after accept", rx_valid, 0);

        // Ready exactly in the completion cycle of the second word: it replaces the first.
        expect_ev(EV_WORD, 8'h11);
        send_frame(8'h11, 1'b1);
        expect_ev(EV_WORD, 8'h22);
        @(posedge clk);
        #1;
        fork
            send_frame(8'h22, 1'b1);
            begin
                repeat (154) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
        join
        @(negedge clk);
        check("replaced word valid", rx_valid, 1);
        @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
        @(negedge clk);
        check("replaced word accepted", rx_valid, 0);

        // Reset after three data bits, with a word pending.
        expect_ev(EV_WORD, 8'h33);
        send_frame(8'h33, 1'b1);
        partial = 8'h77;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(partial[i]);
        @(negedge clk);
        reset = 1'b1;
        rx    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midframe reset rx_data", rx_data, 0);
        check("midframe reset rx_valid", rx_valid, 0);
        check("midframe reset frame_error", rx_frame_error, 0);
        check("midframe reset overrun", rx_overrun, 0);
        check("midframe reset state", dut.state, IDLE);
        @(posedge clk);
        #1 begin
            reset    = 1'b0;
            rx_ready = 1'b1;
        end
        wait_ticks(20);
        expect_ev(EV_WORD, 8'h5A);
        send_frame(8'h5A, 1'b1);

        // Random frames, random tick rate, occasional bad stop bit.
        for (int n = 0; n < 24; n++) begin
            tick_period = $urandom_range(1, 3);
            d           = 8'($urandom);
            stop_ok     = ($urandom_range(0, 4) != 0);
            if (stop_ok) expect_ev(EV_WORD, d);
            else         expect_ev(EV_FERR, 8'h00);
            send_frame(d, stop_ok);
        end

        repeat (20) @(negedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/receiver.md
Name: receiver

Overview:
- UART receive stage. Sits directly downstream of the transmitter: it consumes the serial line the transmitter drives and recovers the parallel data word.
- Uses the same 16x oversampling baud_timer tick, LSB-first framing, one start bit (0) and one stop bit (1).
- Hands each received word to a consumer over a valid/ready handshake.
- Flags framing errors and overruns.

Parameters:
- DATA_LENGTH, 8, number of data bits per frame; also the width of rx_data.

Ports:
- clk  input  1  system clock. One clock; reset is synchronous and active-high.
- reset  input  1  synchronous, active-high reset.
- baud_timer  input  1  single-cycle tick at 16x the baud rate; shared with the transmitter.
- rx  input  1  asynchronous serial line; idles high.
- rx_ready  input  1  consumer accepts rx_data in any cycle where rx_valid=1.
- rx_data  output  DATA_LENGTH  received word; held stable while rx_valid=1.
- rx_valid  output  1  a word is available.
- rx_frame_error  output  1  one-cycle pulse: the stop bit was sampled low.
- rx_overrun  output  1  one-cycle pulse: a new word completed while the previous word was unaccepted.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, rx_frame_error=0, rx_overrun=0, state=IDLE, counters=0, synchroniser flops=1. A reset asserted mid-frame aborts the frame and nothing is delivered.
- rx passes through a 2-flop synchroniser (rx_s). A falling-edge detect uses prev_rx_s=1 and rx_s=0.
- All counters advance only on cycles where baud_timer=1. baud_count is 4 bits; bit_index is clog2(DATA_LENGTH) bits.
- State machine (states IDLE, START, RECEIVE, STOP):
  - IDLE: on a falling edge, baud_count=0, go to START. A line held low with no new edge does not re-trigger.
  - START: on a tick with baud_count==7 (mid-bit), if rx_s==0 then baud_count=0, bit_index=0, go to RECEIVE. Otherwise (glitch) go to IDLE. On other ticks, baud_count++.
  - RECEIVE: on a tick with baud_count==15, shift register = {rx_s, shift[DATA_LENGTH-1:1]} (LSB first), baud_count=0. If bit_index==DATA_LENGTH-1, go to STOP; else bit_index++. On other ticks, baud_count++.
  - STOP: on a tick with baud_count==15, sample rx_s and go to IDLE.
    - If rx_s==1: frame complete.
    - If rx_s==0: rx_frame_error=1 for the next cycle; word discarded; rx_valid unchanged.
- Output register update, applied in the cycle after a good stop sample:
  - If rx_valid==0, or rx_ready==1 in the completion cycle: rx_data=shift, rx_valid=1, no overrun.
  - Otherwise: rx_overrun pulses for 1 cycle, the new word is dropped, and rx_data/rx_valid keep the old word.
- Handshake: when rx_valid & rx_ready, rx_valid clears the next cycle unless a new word loads in that same cycle (see above).
- Latency: the stop-bit sample cycle plus 1 clk to rx_valid. With baud_timer tied high, the start edge on rx leads rx_valid by about 2 (sync) + 8 + 16*DATA_LENGTH + 16 + 1 clk.
- An unused state encoding goes to IDLE.

Decomposition:
- Package uart_pkg holds:
  - state encodings IDLE/START/RECEIVE/STOP (2 bits);
  - OVERSAMPLE=16, MID_SAMPLE=7, LAST_SAMPLE=15.
  - The transmitter may share it later.
- One sub-module, rx_synchronizer: 2-flop synchroniser plus falling-edge detect. Ports: clk, reset, rx, rx_s, rx_fall. Both flops reset to 1.

Test Plan:
- Frame 0xA5 with correct start/stop, baud_timer tied high, rx_ready=1 -> rx_valid high for exactly 1 cycle, rx_data=0xA5, no error pulses. Repeat in loopback from the transmitter with tx_data=0xA5.
- rx low for 4 ticks then high -> no rx_valid, FSM returns to IDLE; a following 0x3C frame is received correctly.
- Frame 0xFF with stop bit 0 -> rx_frame_error pulses for 1 cycle, rx_valid stays 0. After the line returns high, 0x12 is received correctly.
- Back-to-back 0x11 then 0x22 with rx_ready=0 -> rx_valid=1, rx_data=0x11, rx_overrun pulses once at the second completion, rx_data stays 0x11. Then rx_ready=1 for 1 cycle -> rx_valid drops.
- rx_ready asserted in exactly the completion cycle of 0x22 while 0x11 is pending -> rx_data=0x22, rx_valid stays 1, no overrun.
- Reset asserted after 3 data bits of a frame -> all outputs 0, state IDLE. A subsequent 0x5A frame is received correctly.
